// File: rtl/id_scoreboard_pkg.sv
// Shared register-index widths and the bypass stage entry type for the ID scoreboard.
package id_scoreboard_pkg;

  localparam int unsigned REG_INDEX_SIZE = 5;
  localparam int unsigned REG_INDEX_BUS  = REG_INDEX_SIZE - 1;

  typedef logic [REG_INDEX_BUS:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     is_load;
  } stg_entry_t;

endpackage

// File: rtl/id_scoreboard_match.sv
// One source port's priority compare against the tracked bypass stages.
module id_scoreboard_match
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_STG = 3,
  parameter int unsigned LD_STG  = 2
) (
  input  logic                       rs_en,
  input  reg_idx_t                   rs_index,
  input  stg_entry_t [NUM_STG-1:0]   stg,
  output logic       [NUM_STG:0]     sel,
  output logic                       load_hazard
);

  logic found;

  always_comb begin
    sel         = '0;
    load_hazard = 1'b0;
    found       = 1'b0;
    // Stage 0 is the youngest producer, so the first hit wins.
    for (int k = 0; k < int'(NUM_STG); k++) begin
      if (!found && rs_en && stg[k].valid && (stg[k].rd == rs_index) &&
          (rs_index != '0)) begin
        found = 1'b1;
        if (stg[k].is_load && (k < int'(LD_STG))) begin
          load_hazard = 1'b1;
        end else begin
          sel[k+1] = 1'b1;
        end
      end
    end
    if (!found || load_hazard) begin
      sel[0] = 1'b1;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage bypass select and hazard stall generation.
// Define ID_SCOREBOARD_LONG_OP_EN to track multicycle ops in a busy bitmap.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_RS  = 2,
  parameter int unsigned NUM_STG = 3,
  parameter int unsigned LD_STG  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall_pipe_i,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  input  logic                               issue_rd_en_i,
  input  logic [REG_INDEX_SIZE-1:0]          issue_rd_index_i,
  input  logic                               issue_is_load_i,
  input  logic                               issue_is_long_i,
  input  logic [NUM_RS-1:0]                  rs_en_i,
  input  logic [NUM_RS*REG_INDEX_SIZE-1:0]   rs_index_i,
  input  logic                               long_done_i,
  input  logic [REG_INDEX_SIZE-1:0]          long_done_index_i,
  output logic [NUM_RS*(NUM_STG+1)-1:0]      rs_sel_o,
  output logic                               stall_o
);

  stg_entry_t [NUM_STG-1:0] stg_q, stg_d;
  logic       [NUM_RS-1:0]  load_hz;
  logic       [NUM_RS-1:0]  busy_hz;
  logic                     long_op;
  logic                     issue_ok;

  for (genvar p = 0; p < NUM_RS; p++) begin : g_port
    id_scoreboard_match #(
      .NUM_STG (NUM_STG),
      .LD_STG  (LD_STG)
    ) u_match (
      .rs_en       (rs_en_i[p]),
      .rs_index    (rs_index_i[p*REG_INDEX_SIZE +: REG_INDEX_SIZE]),
      .stg         (stg_q),
      .sel         (rs_sel_o[p*(NUM_STG+1) +: (NUM_STG+1)]),
      .load_hazard (load_hz[p])
    );
  end

  assign stall_o  = |{load_hz, busy_hz};
  assign issue_ok = issue_valid_i & issue_rd_en_i & ~stall_o & ~flush_i;

`ifdef ID_SCOREBOARD_LONG_OP_EN
  logic [(1<<REG_INDEX_SIZE)-1:0] busy_q, busy_d;

  assign long_op = issue_is_long_i;

  always_comb begin
    for (int p = 0; p < int'(NUM_RS); p++) begin
      busy_hz[p] = rs_en_i[p] & busy_q[rs_index_i[p*REG_INDEX_SIZE +: REG_INDEX_SIZE]];
    end
  end

  // Clear first so a same-cycle re-issue to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (long_done_i) begin
      busy_d[long_done_index_i] = 1'b0;
    end
    if (issue_ok && issue_is_long_i && (issue_rd_index_i != '0)) begin
      busy_d[issue_rd_index_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_long;

  assign long_op     = 1'b0;
  assign busy_hz     = '0;
  assign unused_long = ^{issue_is_long_i, long_done_i, long_done_index_i};
`endif

  always_comb begin
    stg_d = stg_q;
    if (stall_pipe_i) begin
      if (flush_i) begin
        stg_d[0].valid = 1'b0;
      end
    end else begin
      for (int k = 1; k < int'(NUM_STG); k++) begin
        stg_d[k] = stg_q[k-1];
      end
      stg_d[0].valid   = issue_ok & ~long_op;
      stg_d[0].rd      = issue_rd_index_i;
      stg_d[0].is_load = issue_is_load_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

endmodule
